// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I core.
// Owns the PC and handles stall, branch flush and the HALT pseudo-instruction.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             halt,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_ifid_pc;
    logic [31:0]      r_ifid_instr;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_fetch_count;

    logic w_run;
    logic w_redirect;
    logic w_halt_take;
    logic w_fetch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority: branch (older instruction) > halt of a valid ID instruction > stall > fetch.
    always_comb begin
        w_run        = (r_state == S_RUN);
        w_redirect   = w_run & branch_taken;
        w_halt_take  = w_run & ~branch_taken & halt & r_ifid_valid;
        w_fetch      = w_run & ~branch_taken & ~w_halt_take & ~stall;
        w_state_next = r_state;
        if (w_halt_take) begin
            w_state_next = S_HALTED;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_ifid_pc     <= '0;
            r_ifid_instr  <= NOP;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= '0;
        end else if (w_redirect) begin
            r_pc         <= branch_target & ~32'h3;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
        end else if (w_halt_take) begin
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
        end else if (w_fetch) begin
            r_pc         <= r_pc + 32'd4;
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= imem_rdata;
            r_ifid_valid <= 1'b1;
            if (r_fetch_count != '1) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
        end
    end

    assign imem_addr   = r_pc;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_valid  = r_ifid_valid;
    assign halted      = (r_state == S_HALTED);
    assign fetch_count = r_fetch_count;

endmodule
